// File: rtl/status_register_bank.sv
// Multi-channel status register bank: I/O logic writes masked level/sticky bits,
// the processor reads by address, clears sticky bits (write-1-to-clear) and sees change flags and an interrupt.
module status_register_bank #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter logic [NUM_CHANNELS*DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [NUM_CHANNELS*DATA_WIDTH-1:0] STICKY_MASK = '0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Sys_RegSelect,
  input  logic [ADDR_WIDTH-1:0]   Sys_Addr,
  input  logic                    Sys_RdEn,
  output logic [DATA_WIDTH-1:0]   Sys_RdData,
  input  logic                    Sys_ClrEn,
  input  logic [DATA_WIDTH-1:0]   Sys_ClrData,
  output logic [NUM_CHANNELS-1:0] Sys_Changed,
  output logic                    Sys_Irq,
  input  logic                    IO_WrEn,
  input  logic [ADDR_WIDTH-1:0]   IO_WrChannel,
  input  logic [DATA_WIDTH-1:0]   IO_WrData,
  input  logic [DATA_WIDTH-1:0]   IO_WrMask
);

  // Strobes are single-cycle qualifiers sampled on the rising edge; there is no
  // backpressure, so read, clear and IO write are all accepted in any cycle.

  logic [DATA_WIDTH-1:0]   words_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   words_d [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   io_word [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] sticky_hit;
  logic [NUM_CHANNELS-1:0] changed_q, changed_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    irq_q, irq_d;
  logic                    rd_hit;
  logic                    clr_hit;

  assign rd_hit  = Sys_RegSelect && Sys_RdEn;
  assign clr_hit = Sys_RegSelect && Sys_ClrEn;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    logic [DATA_WIDTH-1:0] sticky;
    logic [DATA_WIDTH-1:0] wr_bits;
    logic [DATA_WIDTH-1:0] set_bits;
    logic [DATA_WIDTH-1:0] clr_bits;

    assign sticky   = STICKY_MASK[g*DATA_WIDTH +: DATA_WIDTH];
    assign wr_bits  = (IO_WrEn && IO_WrChannel == ADDR_WIDTH'(g)) ? IO_WrMask : '0;
    assign set_bits = IO_WrData & wr_bits & sticky;
    assign clr_bits = (clr_hit && Sys_Addr == ADDR_WIDTH'(g)) ? (Sys_ClrData & sticky) : '0;

    // io_word is the IO-only result; it drives the change flag, which ignores clears.
    assign io_word[g] = (((words_q[g] & ~wr_bits) | (IO_WrData & wr_bits)) & ~sticky)
                      | ((words_q[g] | set_bits) & sticky);
    // Re-applying set_bits after the clear makes a simultaneous set win.
    assign words_d[g] = (io_word[g] & ~clr_bits) | set_bits;
    assign sticky_hit[g] = |(words_q[g] & sticky);
  end

  always_comb begin
    rd_data_d = rd_data_q;
    changed_d = changed_q;
    irq_d     = |sticky_hit;
    if (rd_hit) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (Sys_Addr == ADDR_WIDTH'(i)) rd_data_d = words_q[i];
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_hit && Sys_Addr == ADDR_WIDTH'(i)) changed_d[i] = 1'b0;
      if (io_word[i] != words_q[i]) changed_d[i] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        words_q[i] <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
      end
      rd_data_q <= '0;
      changed_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        words_q[i] <= words_d[i];
      end
      rd_data_q <= rd_data_d;
      changed_q <= changed_d;
      irq_q     <= irq_d;
    end
  end

  assign Sys_RdData  = rd_data_q;
  assign Sys_Changed = changed_q;
  assign Sys_Irq     = irq_q;

endmodule

// File: tb/tb_status_register_bank.sv
// Self-checking bench for status_register_bank: directed scenarios plus randomized
// traffic compared against a behavioural model of the status words.
module tb_status_register_bank;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int AW = 3;
  localparam logic [NC*DW-1:0] RV = {32'h0, 32'h0000_00A5, 32'h0, 32'h0};
  localparam logic [NC*DW-1:0] SM = {32'h0, 32'h0, 32'h0000_00FF, 32'h0};

  logic          Clock;
  logic          Reset;
  logic          Sys_RegSelect;
  logic [AW-1:0] Sys_Addr;
  logic          Sys_RdEn;
  logic [DW-1:0] Sys_RdData;
  logic          Sys_ClrEn;
  logic [DW-1:0] Sys_ClrData;
  logic [NC-1:0] Sys_Changed;
  logic          Sys_Irq;
  logic          IO_WrEn;
  logic [AW-1:0] IO_WrChannel;
  logic [DW-1:0] IO_WrData;
  logic [DW-1:0] IO_WrMask;

  status_register_bank #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .ADDR_WIDTH(AW),
    .RESET_VALUE(RV), .STICKY_MASK(SM)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .Sys_RegSelect(Sys_RegSelect), .Sys_Addr(Sys_Addr), .Sys_RdEn(Sys_RdEn),
    .Sys_RdData(Sys_RdData), .Sys_ClrEn(Sys_ClrEn), .Sys_ClrData(Sys_ClrData),
    .Sys_Changed(Sys_Changed), .Sys_Irq(Sys_Irq),
    .IO_WrEn(IO_WrEn), .IO_WrChannel(IO_WrChannel), .IO_WrData(IO_WrData),
    .IO_WrMask(IO_WrMask)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_word [NC];
  logic [DW-1:0] m_sticky [NC];
  logic [NC-1:0] m_chg;
  logic [DW-1:0] m_rd;
  logic          m_irq;
  logic [DW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_word[c]   = RV[c*DW +: DW];
      m_sticky[c] = SM[c*DW +: DW];
    end
    m_chg = '0;
    m_rd  = '0;
    m_irq = 1'b0;
  endtask

  task automatic idle_inputs();
    Sys_RegSelect = 1'b0; Sys_Addr = '0; Sys_RdEn = 1'b0; Sys_ClrEn = 1'b0;
    Sys_ClrData = '0; IO_WrEn = 1'b0; IO_WrChannel = '0; IO_WrData = '0; IO_WrMask = '0;
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // return at the next falling edge where outputs are stable for sampling.
  task automatic cycle(input bit wr, input int wch, input logic [DW-1:0] wd,
                       input logic [DW-1:0] wm, input bit sel, input bit rd,
                       input bit clr, input int addr, input logic [DW-1:0] cd);
    logic [DW-1:0] pre [NC];
    logic [DW-1:0] level, set, clear, io_only;
    bit wr_here, clr_here;
    Sys_RegSelect = sel; Sys_Addr = AW'(addr); Sys_RdEn = rd; Sys_ClrEn = clr;
    Sys_ClrData = cd; IO_WrEn = wr; IO_WrChannel = AW'(wch); IO_WrData = wd; IO_WrMask = wm;
    @(posedge Clock);
    pre = m_word;
    if (sel && rd) begin
      m_rd = (addr < NC) ? pre[addr] : '0;
      exp_q.push_back(m_rd);
    end
    m_irq = 1'b0;
    for (int c = 0; c < NC; c++) m_irq = m_irq | (|(pre[c] & m_sticky[c]));
    for (int c = 0; c < NC; c++) begin
      wr_here  = wr && (wch == c);
      clr_here = sel && clr && (addr == c);
      level    = wr_here ? ((pre[c] & ~wm) | (wd & wm)) : pre[c];
      set      = wr_here ? (wd & wm) : '0;
      clear    = clr_here ? cd : '0;
      io_only  = (level & ~m_sticky[c]) | ((pre[c] | set) & m_sticky[c]);
      m_word[c] = (level & ~m_sticky[c]) | (((pre[c] & ~clear) | set) & m_sticky[c]);
      if (sel && rd && addr == c) m_chg[c] = 1'b0;
      if (wr_here && io_only != pre[c]) m_chg[c] = 1'b1;
    end
    @(negedge Clock);
    idle_inputs();
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    idle_inputs();
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [DW-1:0] got;
    do_reset();
    n_cmp++; if (Sys_RdData !== 32'h0) begin n_err++; $display("FAIL reset_rd got=%h exp=%h", Sys_RdData, 32'h0); end
    n_cmp++; if (Sys_Changed !== 4'h0) begin n_err++; $display("FAIL reset_chg got=%h exp=%h", Sys_Changed, 4'h0); end
    n_cmp++; if (Sys_Irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", Sys_Irq); end
    cycle(0, 0, 0, 0, 1, 1, 0, 2, 0);
    got = exp_q.pop_front();
    n_cmp++; if (Sys_RdData !== 32'h0000_00A5 || got !== 32'h0000_00A5) begin n_err++; $display("FAIL reset_rd_ch2 got=%h exp=%h", Sys_RdData, 32'h0000_00A5); end
  endtask

  task automatic test_level_write();
    cycle(1, 0, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1, 0, 0, 0);
    void'(exp_q.pop_front());
    cycle(0, 0, 0, 0, 1, 1, 0, 0, 0);
    void'(exp_q.pop_front());
    cycle(1, 0, 32'hFFFF_0000, 32'h00FF_FF00, 0, 0, 0, 0, 0);
    n_cmp++; if (Sys_Changed !== 4'b0001) begin n_err++; $display("FAIL level_chg got=%b exp=%b", Sys_Changed, 4'b0001); end
    cycle(0, 0, 0, 0, 1, 1, 0, 0, 0);
    void'(exp_q.pop_front());
    n_cmp++; if (Sys_RdData !== 32'h12FF_0078) begin n_err++; $display("FAIL level_rd got=%h exp=%h", Sys_RdData, 32'h12FF_0078); end
    n_cmp++; if (Sys_Changed !== 4'b0000) begin n_err++; $display("FAIL level_chg_clr got=%b exp=%b", Sys_Changed, 4'b0000); end
  endtask

  task automatic test_sticky();
    cycle(1, 1, 32'h05, 32'hFF, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (Sys_Irq !== 1'b1) begin n_err++; $display("FAIL sticky_irq_set got=%b exp=1", Sys_Irq); end
    cycle(1, 1, 32'h00, 32'hFF, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 0, 1, 0);
    void'(exp_q.pop_front());
    n_cmp++; if (Sys_RdData !== 32'h05) begin n_err++; $display("FAIL sticky_keep got=%h exp=%h", Sys_RdData, 32'h05); end
    cycle(0, 0, 0, 0, 1, 0, 1, 1, 32'h01);
    cycle(0, 0, 0, 0, 1, 1, 0, 1, 0);
    void'(exp_q.pop_front());
    n_cmp++; if (Sys_RdData !== 32'h04) begin n_err++; $display("FAIL sticky_clr1 got=%h exp=%h", Sys_RdData, 32'h04); end
    cycle(0, 0, 0, 0, 1, 0, 1, 1, 32'h04);
    n_cmp++; if (Sys_Irq !== 1'b1) begin n_err++; $display("FAIL sticky_irq_lag got=%b exp=1", Sys_Irq); end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (Sys_Irq !== 1'b0) begin n_err++; $display("FAIL sticky_irq_clr got=%b exp=0", Sys_Irq); end
  endtask

  task automatic test_collision();
    cycle(1, 1, 32'h01, 32'h01, 1, 1, 1, 1, 32'h01);
    void'(exp_q.pop_front());
    n_cmp++; if (Sys_RdData !== 32'h00) begin n_err++; $display("FAIL coll_rd_pre got=%h exp=%h", Sys_RdData, 32'h00); end
    n_cmp++; if (Sys_Changed[1] !== 1'b1) begin n_err++; $display("FAIL coll_chg got=%b exp=1", Sys_Changed[1]); end
    cycle(0, 0, 0, 0, 1, 1, 0, 1, 0);
    void'(exp_q.pop_front());
    n_cmp++; if (Sys_RdData !== 32'h01) begin n_err++; $display("FAIL coll_set_wins got=%h exp=%h", Sys_RdData, 32'h01); end
  endtask

  task automatic test_out_of_range();
    logic [NC-1:0] chg_before;
    chg_before = Sys_Changed;
    cycle(1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 7, 32'hFFFF_FFFF);
    void'(exp_q.pop_front());
    n_cmp++; if (Sys_RdData !== 32'h0) begin n_err++; $display("FAIL oor_rd got=%h exp=%h", Sys_RdData, 32'h0); end
    n_cmp++; if (Sys_Changed !== chg_before) begin n_err++; $display("FAIL oor_chg got=%b exp=%b", Sys_Changed, chg_before); end
    for (int c = 0; c < NC; c++) begin
      cycle(0, 0, 0, 0, 1, 1, 0, c, 0);
      void'(exp_q.pop_front());
      n_cmp++; if (Sys_RdData !== m_word[c]) begin n_err++; $display("FAIL oor_state ch%0d got=%h exp=%h", c, Sys_RdData, m_word[c]); end
    end
  endtask

  task automatic test_random();
    bit wr, sel, rd, clr;
    logic [DW-1:0] e;
    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1)); sel = 1'($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1)); clr = 1'($urandom_range(0, 1));
      cycle(wr, $urandom_range(0, 5), $urandom, $urandom, sel, rd, clr,
            $urandom_range(0, 5), $urandom);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : m_rd;
      n_cmp++; if (Sys_RdData !== e) begin n_err++; $display("FAIL rand_rd n=%0d got=%h exp=%h", n, Sys_RdData, e); end
      n_cmp++; if (Sys_Changed !== m_chg) begin n_err++; $display("FAIL rand_chg n=%0d got=%b exp=%b", n, Sys_Changed, m_chg); end
      n_cmp++; if (Sys_Irq !== m_irq) begin n_err++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, Sys_Irq, m_irq); end
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 1, 32'h80, 32'h80, 1, 1, 0, 1, 0);
    void'(exp_q.pop_front());
    Sys_RegSelect = 1'b1; Sys_RdEn = 1'b1; Sys_Addr = 3'd0;
    IO_WrEn = 1'b1; IO_WrChannel = 3'd0; IO_WrData = 32'hDEAD_BEEF; IO_WrMask = '1;
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    n_cmp++; if (Sys_RdData !== 32'h0) begin n_err++; $display("FAIL arst_rd got=%h exp=%h", Sys_RdData, 32'h0); end
    n_cmp++; if (Sys_Changed !== 4'h0) begin n_err++; $display("FAIL arst_chg got=%b exp=%b", Sys_Changed, 4'h0); end
    n_cmp++; if (Sys_Irq !== 1'b0) begin n_err++; $display("FAIL arst_irq got=%b exp=0", Sys_Irq); end
    model_reset();
    exp_q.delete();
    @(negedge Clock);
    idle_inputs();
    Reset = 1'b1;
    cycle(1, 3, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 1, 0, 2, 0);
    void'(exp_q.pop_front());
    n_cmp++; if (Sys_RdData !== 32'h0000_00A5) begin n_err++; $display("FAIL arst_state got=%h exp=%h", Sys_RdData, 32'h0000_00A5); end
    cycle(0, 0, 0, 0, 1, 1, 0, 3, 0);
    void'(exp_q.pop_front());
    n_cmp++; if (Sys_RdData !== 32'hCAFE_F00D) begin n_err++; $display("FAIL arst_post_wr got=%h exp=%h", Sys_RdData, 32'hCAFE_F00D); end
    n_cmp++; if (Sys_Changed !== 4'b0000) begin n_err++; $display("FAIL arst_post_chg got=%b exp=%b", Sys_Changed, 4'b0000); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    Reset = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_level_write();
    test_sticky();
    test_collision();
    test_out_of_range();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/status_register_bank.md
Name: status_register_bank

Overview:
Multi-channel successor to the single I/O read-only register. It holds NUM_CHANNELS status words that I/O logic writes under a per-bit mask and the processor reads by address. Bits are individually configured as level (overwrite) or sticky (set-only, processor write-1-to-clear). The block adds per-channel change flags and an interrupt output. It runs in one clock domain; any clock-domain crossing happens upstream of IO_Wr*.

Parameters:
DATA_WIDTH, 32, bits per channel word
NUM_CHANNELS, 4, number of status words (>=1)
ADDR_WIDTH, $clog2(NUM_CHANNELS) clamped to >=1, width of channel/address fields
RESET_VALUE, '0 [NUM_CHANNELS*DATA_WIDTH], flattened reset image; channel i = bits [i*DATA_WIDTH +: DATA_WIDTH]
STICKY_MASK, '0 [NUM_CHANNELS*DATA_WIDTH], flattened; 1 = sticky bit, 0 = level bit

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset
Sys_RegSelect  input  1  processor selects this bank
Sys_Addr  input  ADDR_WIDTH  channel index for read/clear
Sys_RdEn  input  1  read strobe
Sys_RdData  output  DATA_WIDTH  registered read data
Sys_ClrEn  input  1  clear strobe
Sys_ClrData  input  DATA_WIDTH  write-1-to-clear pattern for sticky bits
Sys_Changed  output  NUM_CHANNELS  per-channel "modified since last read" flags
Sys_Irq  output  1  registered OR of all set sticky bits
IO_WrEn  input  1  I/O write strobe
IO_WrChannel  input  ADDR_WIDTH  target channel
IO_WrData  input  DATA_WIDTH  write data
IO_WrMask  input  DATA_WIDTH  per bit: 1 = write, 0 = keep

Behaviour:
- Reset (asserted low, async): channel words = RESET_VALUE; Sys_RdData = 0; Sys_Changed = 0; Sys_Irq = 0. Sys_Irq reflects sticky reset bits one cycle after reset release.
- IO write (IO_WrEn=1, IO_WrChannel < NUM_CHANNELS):
  - Level bits: new = (old & ~mask) | (data & mask).
  - Sticky bits: new = old | (data & mask). An IO write never clears a sticky bit.
- IO_WrChannel >= NUM_CHANNELS: write ignored, no flag change.
- Processor clear (Sys_RegSelect & Sys_ClrEn, Sys_Addr valid): sticky bits where Sys_ClrData=1 go to 0. Level bits are unaffected. Out-of-range address is ignored.
- Same cycle, same bit, IO set and processor clear: set wins, bit = 1.
- Same cycle, different bits or channels: both take effect.
- Read (Sys_RegSelect & Sys_RdEn): Sys_RdData <= word[Sys_Addr] as it was before this cycle's updates.
  - Latency is 1 cycle.
  - Out-of-range address returns 0.
  - Sys_RdData holds its value when no read occurs.
- Sys_Changed[i]: set when an IO write to channel i produces new != old. It is not set by a write that changes nothing, and not by processor clears. It is cleared by a read of channel i. Set and read in the same cycle: set wins.
- Sys_Irq: registered OR over all sticky-bit positions of all channels, one cycle after state change.
- Read, clear and IO write may all occur in one cycle with no priority stall. The block has no busy/backpressure.

Test Plan:
1. Reset (DW=32, NC=4, RESET_VALUE ch2=0x0000_00A5, STICKY_MASK ch1=0x0000_00FF) -> read ch2 gives 0xA5 one cycle after strobe; Sys_Changed=0; Sys_Irq=0.
2. Level masked write ch0 old 0x1234_5678, data 0xFFFF_0000, mask 0x00FF_FF00 -> ch0 = 0x12FF_0078; Sys_Changed[0]=1; read ch0 clears it the next cycle.
3. Sticky ch1: IO write data 0x05 mask 0xFF -> ch1 = 0x05, Sys_Irq=1 next cycle. Then IO data 0x00 mask 0xFF -> ch1 stays 0x05. Clear 0x01 -> 0x04. Clear 0x04 -> 0, Sys_Irq=0 the cycle after.
4. Same-cycle IO set of ch1 bit0 and clear of ch1 bit0, plus read of ch1 -> bit0 = 1 after the edge; RdData shows the pre-update value; Sys_Changed[1] = 1 (set wins over read-clear).
5. IO_WrChannel=5 and Sys_Addr=7 with NUM_CHANNELS=4 -> no state change; read returns 0x0000_0000.
6. Assert Reset mid-stream (IO write and read active) -> all outputs 0 immediately (async), state = RESET_VALUE, no write is lost after release.
